packet_buffer_ingress_arbiter: RTL and testbench
================================================

Name: packet_buffer_ingress_arbiter

Overview:
Shares the single packet buffer write stream between NUM_IFACES capture interfaces. It arbitrates round-robin at packet granularity and validates each packet's declared length. For each accepted packet it emits one packet_header_t beat, then passes the payload through unchanged. Out-of-range packets are drained and counted, never written. It sits between the per-port MAC/ingress adapters and the packet buffer write side.

Parameters:
NUM_IFACES, 4, number of requesting interfaces (2..16); the interface index becomes header interface_id.
DATA_WIDTH, 32, stream width; fixed equal to PACKET_HEADER_T_WIDTH, so the header is one beat and there are 4 bytes per beat.

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
s_tvalid  in  NUM_IFACES  per-interface beat valid
s_tdata  in  NUM_IFACES*DATA_WIDTH  per-interface payload, interface i at slice i
s_tlast  in  NUM_IFACES  per-interface last beat
s_tlen  in  NUM_IFACES*16  packet length in bytes, FCS included; held stable from first beat until that beat is accepted
s_tready  out  NUM_IFACES  per-interface ready
m_tvalid  out  1  to packet buffer
m_tdata  out  DATA_WIDTH  header or payload
m_tlast  out  1  last payload beat
m_thdr  out  1  marks the header beat
m_tready  in  1  packet buffer ready
drop_pulse  out  1  one-cycle pulse per dropped (length-invalid) packet
err_pulse  out  1  one-cycle pulse per length/tlast mismatch
grant  out  NUM_IFACES  one-hot owner, 0 in IDLE

Behaviour:
- Reset, asynchronous: state=IDLE, rr pointer=0 (interface 0 highest priority), all outputs 0, beat counter 0.
- A request is s_tvalid[i]=1 while in IDLE.
- IDLE: pick the first requester at or after the rr pointer, cyclically.
  - Latch len=s_tlen[i] and the index.
  - Set rr pointer to index+1, wrapping modulo NUM_IFACES.
  - Go to HEADER if 64 <= len <= 1504 (MAX_ETH_FRAME_LENGTH+ETH_FCS_LENGTH), else go to DRAIN.
  - Decision takes 1 cycle; grant is registered.
- HEADER:
  - m_tvalid=1, m_thdr=1, m_tdata[15:0]=len, m_tdata[31:16]=index (zero-extended).
  - All s_tready=0.
  - On m_tready, load beats_left=ceil(len/4) and go to PAYLOAD.
- PAYLOAD: combinational passthrough, zero latency.
  - m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], s_tready[g]=m_tready; other s_tready=0.
  - On each handshake, decrement beats_left.
  - s_tlast on a beat with beats_left>1: m_tlast=1, err_pulse, go IDLE (truncated packet).
  - beats_left==1 with s_tlast=1: m_tlast=1, go IDLE.
  - beats_left==1 with s_tlast=0: force m_tlast=1, err_pulse, go DRAIN to discard the remainder of the source packet.
- DRAIN:
  - s_tready[g]=1, m_tvalid=0.
  - Consume beats until the s_tlast handshake, then go IDLE.
  - drop_pulse fires on DRAIN entry from IDLE only; the overrun path is counted by err_pulse.
- No packet interleaving: grant is held until tlast is consumed. Minimum 1 IDLE cycle between packets.
- Simultaneous requests: only the rr order decides. An interface that was just granted has lowest priority next time.
- Single requester: re-granted every packet with no starvation penalty.
- m_tready low holds HEADER/PAYLOAD indefinitely; outputs stay stable while m_tvalid=1 and m_tready=0.
- Reset mid-packet: immediate return to IDLE. A partial packet in the buffer is the downstream's concern; sources are reset on the same rst.

Optional Feature:
PKT_BUF_ARB_STATS_EN
- Defined: adds outputs pkt_count (NUM_IFACES*32), drop_count (32) and err_count (32).
  - pkt_count[i] increments on each header handshake for interface i.
  - drop_count and err_count increment with their pulses.
  - All counters saturate at all-ones and clear on rst.
- Undefined: these ports and counters do not exist; the pulses are unaffected.

Test Plan:
- Iface 2, len=64, 16 beats with tlast on 16th, m_tready=1 -> header 0x0002_0040 with m_thdr=1, then 16 beats passed unchanged, m_tlast on 16th, no pulses.
- Ifaces 0,1,3 requesting continuously with len=100 -> grants in order 0,1,3,0,1,3; each packet = 1 header + 25 beats.
- Iface 1, len=1600 with 400 beats -> no m_tvalid, 400 beats consumed, drop_pulse=1 once; len=63 gives the same result.
- len=128 but tlast on beat 20 -> beat 20 emitted with m_tlast=1, err_pulse=1, back to IDLE.
- len=128 but tlast on beat 40 -> m_tlast forced on beat 32, err_pulse=1, beats 33-40 drained.
- m_tready toggling 1-0 during payload, plus rst asserted mid-payload -> data stable while stalled; after rst, grant=0, m_tvalid=0 and rr restarts at iface 0.

Source files
------------

// File: rtl/packet_buffer_ingress_arbiter.sv
// Round-robin, packet-granular arbiter feeding one packet buffer write stream from NUM_IFACES sources.
// Optional saturating statistics counters are enabled by defining PKT_BUF_ARB_STATS_EN.
module packet_buffer_ingress_arbiter #(
    parameter int NUM_IFACES = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_IFACES-1:0]            s_tvalid,
    input  logic [NUM_IFACES*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_IFACES-1:0]            s_tlast,
    input  logic [NUM_IFACES*16-1:0]         s_tlen,
    output logic [NUM_IFACES-1:0]            s_tready,
    output logic                             m_tvalid,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic                             m_tlast,
    output logic                             m_thdr,
    input  logic                             m_tready,
    output logic                             drop_pulse,
    output logic                             err_pulse,
    output logic [NUM_IFACES-1:0]            grant
`ifdef PKT_BUF_ARB_STATS_EN
    ,
    output logic [NUM_IFACES*32-1:0]         pkt_count,
    output logic [31:0]                      drop_count,
    output logic [31:0]                      err_count
`endif
);

    localparam int          IDX_W   = $clog2(NUM_IFACES);
    localparam logic [15:0] MIN_LEN = 16'd64;
    localparam logic [15:0] MAX_LEN = 16'd1504;

    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_DRAIN} state_t;

    // Returns {found, index} of the first requester at or after ptr, cyclically.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_IFACES-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = 0; k < NUM_IFACES; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_IFACES) j = j - NUM_IFACES;
            if (!res[IDX_W] && req[j]) res = {1'b1, IDX_W'(j)};
        end
        return res;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_rr;
    logic [IDX_W-1:0]       r_idx;
    logic [15:0]            r_len;
    logic [15:0]            r_beats_left;
    logic [NUM_IFACES-1:0]  r_grant;
    logic                   r_drop_pulse;
    logic                   r_err_pulse;

    logic [IDX_W:0]         w_pick_res;
    logic                   w_req_found;
    logic [IDX_W-1:0]       w_pick;
    logic [IDX_W-1:0]       w_rr_nxt;
    logic [15:0]            w_req_len;
    logic                   w_len_ok;
    logic                   w_g_valid;
    logic                   w_g_last;
    logic [DATA_WIDTH-1:0]  w_g_data;
    logic                   w_last_beat;
    logic [DATA_WIDTH-1:0]  w_hdr;
    logic                   w_drop_set;
    logic                   w_err_set;

    assign w_pick_res  = rr_pick(s_tvalid, r_rr);
    assign w_req_found = w_pick_res[IDX_W];
    assign w_pick      = w_pick_res[IDX_W-1:0];
    assign w_rr_nxt    = (w_pick == IDX_W'(NUM_IFACES - 1)) ? '0 : w_pick + 1'b1;
    assign w_req_len   = s_tlen[w_pick*16 +: 16];
    assign w_len_ok    = (w_req_len >= MIN_LEN) && (w_req_len <= MAX_LEN);

    assign w_g_valid   = s_tvalid[r_idx];
    assign w_g_last    = s_tlast[r_idx];
    assign w_g_data    = s_tdata[r_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_last_beat = (r_beats_left == 16'd1);
    assign w_hdr       = DATA_WIDTH'({{(16-IDX_W){1'b0}}, r_idx, r_len});

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        s_tready    = '0;
        m_tvalid    = 1'b0;
        m_tdata     = '0;
        m_tlast     = 1'b0;
        m_thdr      = 1'b0;
        w_drop_set  = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_found) begin
                    if (w_len_ok) begin
                        w_state_nxt = ST_HEADER;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                        w_drop_set  = 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                m_tvalid = 1'b1;
                m_thdr   = 1'b1;
                m_tdata  = w_hdr;
                if (m_tready) w_state_nxt = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                m_tvalid        = w_g_valid;
                m_tdata         = w_g_data;
                m_tlast         = w_g_valid & (w_g_last | w_last_beat);
                s_tready[r_idx] = m_tready;
                if (w_g_valid && m_tready) begin
                    if (w_last_beat) begin
                        // Declared length exhausted: a missing tlast means the source overran.
                        if (w_g_last) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                            w_err_set   = 1'b1;
                        end
                    end else if (w_g_last) begin
                        w_state_nxt = ST_IDLE;
                        w_err_set   = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                s_tready[r_idx] = 1'b1;
                if (w_g_valid && w_g_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: reset sits in the sensitivity list so it acts without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rr         <= '0;
            r_idx        <= '0;
            r_len        <= '0;
            r_beats_left <= '0;
            r_grant      <= '0;
            r_drop_pulse <= 1'b0;
            r_err_pulse  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            r_state      <= w_state_nxt;
            r_drop_pulse <= w_drop_set;
            r_err_pulse  <= w_err_set;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_found) begin
                        r_idx   <= w_pick;
                        r_len   <= w_req_len;
                        r_rr    <= w_rr_nxt;
                        r_grant <= NUM_IFACES'(1) << w_pick;
                    end
                end
                ST_HEADER: begin
                    if (m_tready) r_beats_left <= (r_len + 16'd3) >> 2;
                end
                ST_PAYLOAD: begin
                    if (w_g_valid && m_tready) r_beats_left <= r_beats_left - 16'd1;
                end
                default: ;
            endcase
            if (r_state != ST_IDLE && w_state_nxt == ST_IDLE) r_grant <= '0;
        end
    end

    assign grant      = r_grant;
    assign drop_pulse = r_drop_pulse;
    assign err_pulse  = r_err_pulse;

`ifdef PKT_BUF_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_IFACES; gi++) begin : g_pkt_cnt
        logic [31:0] r_cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (r_state == ST_HEADER && m_tready && r_idx == IDX_W'(gi) && r_cnt != '1) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
        assign pkt_count[gi*32 +: 32] = r_cnt;
    end

    logic [31:0] r_drop_count;
    logic [31:0] r_err_count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_count <= '0;
            r_err_count  <= '0;
        end else begin
            if (r_drop_pulse && r_drop_count != '1) r_drop_count <= r_drop_count + 32'd1;
            if (r_err_pulse && r_err_count != '1)   r_err_count  <= r_err_count + 32'd1;
        end
    end
    assign drop_count = r_drop_count;
    assign err_count  = r_err_count;
`else
    // Without statistics the drop/err pulses are the only event indication.
`endif

endmodule

// File: tb/tb_packet_buffer_ingress_arbiter.sv
// Scoreboard bench for packet_buffer_ingress_arbiter: expected beats are queued as packets are
// launched and compared at each downstream handshake; pulse counts are compared per scenario.
module tb_packet_buffer_ingress_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      s_tvalid;
    logic [N*DW-1:0]   s_tdata;
    logic [N-1:0]      s_tlast;
    logic [N*16-1:0]   s_tlen;
    logic [N-1:0]      s_tready;
    logic              m_tvalid;
    logic [DW-1:0]     m_tdata;
    logic              m_tlast;
    logic              m_thdr;
    logic              m_tready;
    logic              drop_pulse;
    logic              err_pulse;
    logic [N-1:0]      grant;
`ifdef PKT_BUF_ARB_STATS_EN
    logic [N*32-1:0]   pkt_count;
    logic [31:0]       drop_count;
    logic [31:0]       err_count;
`endif

    packet_buffer_ingress_arbiter #(.NUM_IFACES(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tlen(s_tlen),
        .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_thdr(m_thdr),
        .m_tready(m_tready),
        .drop_pulse(drop_pulse), .err_pulse(err_pulse), .grant(grant)
`ifdef PKT_BUF_ARB_STATS_EN
        , .pkt_count(pkt_count), .drop_count(drop_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hdr;
        logic        last;
        logic [31:0] data;
    } beat_t;

    beat_t       sb_q[$];
    beat_t       mon_b;
    logic [N-1:0] mon_exp_g;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_drop   = 0;
    int          n_err    = 0;
    int          exp_drop = 0;
    int          exp_err  = 0;
    int          n_pops   = 0;
    logic        abort      = 1'b0;
    logic        rdy_toggle = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_data(input int i, input int pkt, input int b);
        return {8'(8'hA0 + i), 8'(pkt), 16'(b)};
    endfunction

    // Expected downstream view of one source packet, derived from the length rules.
    task automatic push_pkt(input int i, input int len, input int nb, input int pkt);
        beat_t e;
        int    need;
        int    ne;
        if (len < 64 || len > 1504) begin
            exp_drop++;
            return;
        end
        need   = (len + 3) / 4;
        ne     = (nb < need) ? nb : need;
        e.hdr  = 1'b1;
        e.last = 1'b0;
        e.data = {16'(i), 16'(len)};
        sb_q.push_back(e);
        for (int b = 0; b < ne; b++) begin
            e.hdr  = 1'b0;
            e.last = (b == ne - 1);
            e.data = mk_data(i, pkt, b);
            sb_q.push_back(e);
        end
        if (nb != need) exp_err++;
    endtask

    task automatic send_pkt(input int i, input int len, input int nb, input int pkt);
        int t;
        for (int b = 0; b < nb; b++) begin
            s_tvalid[i]          = 1'b1;
            s_tdata[i*DW +: DW]  = mk_data(i, pkt, b);
            s_tlast[i]           = (b == nb - 1);
            s_tlen[i*16 +: 16]   = 16'(len);
            t = 0;
            @(negedge clk);
            while (!s_tready[i] && !abort && t < 4000) begin
                @(negedge clk);
                t++;
            end
            if (abort) break;
            if (t >= 4000) begin
                check("src_timeout", 64'(t), 64'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic finish_test(input string name);
        for (int c = 0; c < 300 && (grant != '0 || sb_q.size() != 0); c++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check($sformatf("%s_q_empty", name), 64'(sb_q.size()), 64'd0);
        check($sformatf("%s_grant_idle", name), 64'(grant), 64'd0);
        check($sformatf("%s_drop_cnt", name), 64'(n_drop), 64'(exp_drop));
        check($sformatf("%s_err_cnt", name), 64'(n_err), 64'(exp_err));
        n_drop   = 0;
        n_err    = 0;
        exp_drop = 0;
        exp_err  = 0;
    endtask

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_toggle) m_tready = ~m_tready;
            else            m_tready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (drop_pulse) n_drop++;
            if (err_pulse)  n_err++;
            if (m_tvalid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 64'(sb_q.size()), 64'd1);
                end else begin
                    if (m_thdr) begin
                        mon_exp_g = '0;
                        mon_exp_g[int'(sb_q[0].data[31:16])] = 1'b1;
                        check("grant_onehot", 64'(grant), 64'(mon_exp_g));
                    end
                    if (m_tready) begin
                        mon_b = sb_q.pop_front();
                        n_pops++;
                        check("beat", {30'b0, m_thdr, m_tlast, m_tdata}, {30'b0, mon_b});
                    end else begin
                        check("stall_hold", {30'b0, m_thdr, m_tlast, m_tdata}, {30'b0, sb_q[0]});
                    end
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        s_tlen   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_pulses", {62'b0, drop_pulse, err_pulse}, 64'd0);
        check("rst_flags", {62'b0, m_thdr, m_tlast}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single well-formed 64-byte packet on interface 2.
        push_pkt(2, 64, 16, 1);
        send_pkt(2, 64, 16, 1);
        finish_test("t1");

        // Three continuous requesters; round-robin from a fresh pointer.
        do_reset();
        push_pkt(0, 100, 25, 10);
        push_pkt(1, 100, 25, 11);
        push_pkt(3, 100, 25, 13);
        push_pkt(0, 100, 25, 20);
        push_pkt(1, 100, 25, 21);
        push_pkt(3, 100, 25, 23);
        fork
            begin send_pkt(0, 100, 25, 10); send_pkt(0, 100, 25, 20); end
            begin send_pkt(1, 100, 25, 11); send_pkt(1, 100, 25, 21); end
            begin send_pkt(3, 100, 25, 13); send_pkt(3, 100, 25, 23); end
        join
        finish_test("t2");

        // Out-of-range lengths are drained silently.
        push_pkt(1, 1600, 400, 30);
        send_pkt(1, 1600, 400, 30);
        push_pkt(1, 63, 16, 31);
        send_pkt(1, 63, 16, 31);
        finish_test("t3");

        // Early tlast truncates the packet.
        push_pkt(1, 128, 20, 40);
        send_pkt(1, 128, 20, 40);
        finish_test("t4");

        // Overrun: tlast forced on beat 32, remainder drained.
        push_pkt(1, 128, 40, 41);
        send_pkt(1, 128, 40, 41);
        finish_test("t5");

        // Backpressure toggling, then reset mid-payload.
        do_reset();
        n_pops     = 0;
        rdy_toggle = 1'b1;
        push_pkt(1, 128, 32, 50);
        fork
            send_pkt(1, 128, 32, 50);
            begin
                for (int c = 0; c < 500 && n_pops < 10; c++) @(posedge clk);
                @(posedge clk);
                #1;
                rst        = 1'b1;
                abort      = 1'b1;
                rdy_toggle = 1'b0;
            end
        join
        check("t6_progress", 64'(n_pops >= 10), 64'd1);
        sb_q.delete();
        @(negedge clk);
        check("t6_rst_grant", 64'(grant), 64'd0);
        check("t6_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        abort    = 1'b0;
        n_drop   = 0;
        n_err    = 0;
        exp_drop = 0;
        exp_err  = 0;
        @(negedge clk);
        check("t6_post_grant", 64'(grant), 64'd0);
        check("t6_post_m_tvalid", 64'(m_tvalid), 64'd0);
        // Interface 2 would win if the pointer survived the reset.
        push_pkt(1, 64, 16, 60);
        push_pkt(2, 64, 16, 61);
        fork
            send_pkt(1, 64, 16, 60);
            send_pkt(2, 64, 16, 61);
        join
        finish_test("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
